// File: rtl/paddle_hit_detector_if.sv
// Signal bundle between the camera/game-controller side and paddle_hit_detector.
// The master drives pixels and ball state; the slave (detector) returns box and hit results.
interface paddle_hit_detector_if;
  logic       upscale;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_is_paddle;
  logic       frame_end;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       is_ball_moving_left;
  logic       paddle_found;
  logic [9:0] paddle_cx;
  logic [9:0] paddle_cy;
  logic [9:0] estimated_speed;
  logic       collision_detected;

  modport master (
    output upscale, pix_valid, pix_x, pix_y, pix_is_paddle, frame_end,
    output ball_x, ball_y, is_ball_moving_left,
    input  paddle_found, paddle_cx, paddle_cy, estimated_speed, collision_detected
  );

  modport slave (
    input  upscale, pix_valid, pix_x, pix_y, pix_is_paddle, frame_end,
    input  ball_x, ball_y, is_ball_moving_left,
    output paddle_found, paddle_cx, paddle_cy, estimated_speed, collision_detected
  );
endinterface

// File: rtl/paddle_hit_detector.sv
// Builds a per-frame paddle bounding box from the thresholded pixel stream, estimates paddle
// speed between frames and emits a single collision pulse per ball/paddle contact.
module paddle_hit_detector #(
  parameter int unsigned BALL_SIZE  = 20,
  parameter int unsigned MIN_PIXELS = 32,
  parameter int unsigned SPEED_MAX  = 1023
) (
  input  logic                  clk_25MHZ,
  input  logic                  reset,
  paddle_hit_detector_if.slave  bus
);

  localparam logic [15:0] LP_MIN_PIXELS = 16'(MIN_PIXELS);
  localparam logic [10:0] LP_SPEED_MAX  = 11'(SPEED_MAX);
  localparam logic [10:0] LP_BS_FULL    = 11'(BALL_SIZE);
  localparam logic [10:0] LP_BS_HALF    = 11'(BALL_SIZE / 2);

  typedef enum logic {StArmed, StCooldown} state_e;

  // Running accumulators for the frame in progress
  logic [9:0]  r_xmin, r_xmax, r_ymin, r_ymax;
  logic [15:0] r_count;
  // Committed box and outputs
  logic [9:0]  r_cxmin, r_cxmax, r_cymin, r_cymax;
  logic        r_found;
  logic [9:0]  r_cx, r_cy, r_speed;
  logic        r_collision;
  logic [9:0]  r_prev_cx, r_prev_cy;
  logic        r_prev_valid;
  logic        r_dir;
  state_e      r_state;
  state_e      w_state_d;
  logic        w_pulse;

  logic        w_hit;
  logic [9:0]  w_xmin_incl, w_xmax_incl, w_ymin_incl, w_ymax_incl;
  logic [15:0] w_count_incl;
  logic        w_found_new;
  logic [10:0] w_sum_x, w_sum_y;
  logic [9:0]  w_cx_new, w_cy_new;
  logic [9:0]  w_dx, w_dy;
  logic [10:0] w_speed_sum;
  logic [9:0]  w_speed_new;
  logic [10:0] w_bx, w_by, w_bs, w_bx_end, w_by_end;
  logic        w_overlap;

  // Accumulator values including a pixel arriving in the current cycle
  assign w_hit        = bus.pix_valid & bus.pix_is_paddle;
  assign w_xmin_incl  = (w_hit && (bus.pix_x < r_xmin)) ? bus.pix_x : r_xmin;
  assign w_xmax_incl  = (w_hit && (bus.pix_x > r_xmax)) ? bus.pix_x : r_xmax;
  assign w_ymin_incl  = (w_hit && (bus.pix_y < r_ymin)) ? bus.pix_y : r_ymin;
  assign w_ymax_incl  = (w_hit && (bus.pix_y > r_ymax)) ? bus.pix_y : r_ymax;
  assign w_count_incl = (w_hit && (r_count != 16'hFFFF)) ? r_count + 16'd1 : r_count;
  assign w_found_new  = (w_count_incl >= LP_MIN_PIXELS);

  assign w_sum_x  = {1'b0, w_xmin_incl} + {1'b0, w_xmax_incl};
  assign w_sum_y  = {1'b0, w_ymin_incl} + {1'b0, w_ymax_incl};
  assign w_cx_new = w_sum_x[10:1];
  assign w_cy_new = w_sum_y[10:1];

  assign w_dx = (w_cx_new >= r_prev_cx) ? (w_cx_new - r_prev_cx) : (r_prev_cx - w_cx_new);
  assign w_dy = (w_cy_new >= r_prev_cy) ? (w_cy_new - r_prev_cy) : (r_prev_cy - w_cy_new);
  assign w_speed_sum = {1'b0, w_dx} + {1'b0, w_dy};
  assign w_speed_new = (w_speed_sum > LP_SPEED_MAX) ? 10'(LP_SPEED_MAX) : w_speed_sum[9:0];

  // Ball box mapped into the camera domain, tested against the committed paddle box
  assign w_bx     = bus.upscale ? {2'b00, bus.ball_x[9:1]} : {1'b0, bus.ball_x};
  assign w_by     = bus.upscale ? {2'b00, bus.ball_y[9:1]} : {1'b0, bus.ball_y};
  assign w_bs     = bus.upscale ? LP_BS_HALF : LP_BS_FULL;
  assign w_bx_end = w_bx + w_bs - 11'd1;
  assign w_by_end = w_by + w_bs - 11'd1;
  assign w_overlap = r_found
                   & (w_bx <= {1'b0, r_cxmax}) & (w_bx_end >= {1'b0, r_cxmin})
                   & (w_by <= {1'b0, r_cymax}) & (w_by_end >= {1'b0, r_cymin});

  always_comb begin
    w_state_d = r_state;
    w_pulse   = 1'b0;
    case (r_state)
      StArmed: begin
        if (w_overlap) begin
          w_pulse   = 1'b1;
          w_state_d = StCooldown;
        end
      end
      StCooldown: begin
        // A direction change means the ball bounced off something, so a new contact may follow
        if ((bus.frame_end && !w_overlap) || (bus.is_ball_moving_left != r_dir)) begin
          w_state_d = StArmed;
        end
      end
      default: w_state_d = StArmed;
    endcase
  end

  always_ff @(posedge clk_25MHZ) begin
    if (reset) begin
      r_state      <= StArmed;
      r_collision  <= 1'b0;
      r_dir        <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_collision  <= w_pulse;
      r_dir        <= bus.is_ball_moving_left;
    end
  end

  always_ff @(posedge clk_25MHZ) begin
    if (reset) begin
      r_xmin       <= 10'd1023;
      r_ymin       <= 10'd1023;
      r_xmax       <= 10'd0;
      r_ymax       <= 10'd0;
      r_count      <= 16'd0;
      r_cxmin      <= 10'd0;
      r_cxmax      <= 10'd0;
      r_cymin      <= 10'd0;
      r_cymax      <= 10'd0;
      r_found      <= 1'b0;
      r_cx         <= 10'd0;
      r_cy         <= 10'd0;
      r_speed      <= 10'd0;
      r_prev_cx    <= 10'd0;
      r_prev_cy    <= 10'd0;
      r_prev_valid <= 1'b0;
    end else if (bus.frame_end) begin
      r_xmin       <= 10'd1023;
      r_ymin       <= 10'd1023;
      r_xmax       <= 10'd0;
      r_ymax       <= 10'd0;
      r_count      <= 16'd0;
      r_cxmin      <= w_xmin_incl;
      r_cxmax      <= w_xmax_incl;
      r_cymin      <= w_ymin_incl;
      r_cymax      <= w_ymax_incl;
      r_found      <= w_found_new;
      r_cx         <= w_cx_new;
      r_cy         <= w_cy_new;
      r_speed      <= (w_found_new && r_prev_valid) ? w_speed_new : 10'd0;
      r_prev_cx    <= w_cx_new;
      r_prev_cy    <= w_cy_new;
      r_prev_valid <= w_found_new;
    end else if (w_hit) begin
      r_xmin       <= w_xmin_incl;
      r_xmax       <= w_xmax_incl;
      r_ymin       <= w_ymin_incl;
      r_ymax       <= w_ymax_incl;
      r_count      <= w_count_incl;
    end
  end

  assign bus.paddle_found       = r_found;
  assign bus.paddle_cx          = r_cx;
  assign bus.paddle_cy          = r_cy;
  assign bus.estimated_speed    = r_speed;
  assign bus.collision_detected = r_collision;

endmodule

// File: tb/tb_paddle_hit_detector.sv
// Directed-vector bench for paddle_hit_detector: box/centre/speed commits, collision pulse
// gating, re-arm paths and mid-frame reset, with hand-computed expected values.
module tb_paddle_hit_detector;

  logic clk;
  logic rst;
  int   n_vectors;
  int   n_miscompares;

  paddle_hit_detector_if u_if ();

  paddle_hit_detector #(
    .BALL_SIZE  (20),
    .MIN_PIXELS (32),
    .SPEED_MAX  (1023)
  ) u_dut (
    .clk_25MHZ (clk),
    .reset     (rst),
    .bus       (u_if)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_block(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        u_if.pix_valid     = 1'b1;
        u_if.pix_is_paddle = 1'b1;
        u_if.pix_x         = 10'(x);
        u_if.pix_y         = 10'(y);
        tick();
      end
    end
    u_if.pix_valid     = 1'b0;
    u_if.pix_is_paddle = 1'b0;
  endtask

  task automatic end_frame();
    u_if.frame_end = 1'b1;
    tick();
    u_if.frame_end = 1'b0;
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (u_if.collision_detected) pulses++;
    end
  endtask

  int pulses;

  initial begin
    n_vectors               = 0;
    n_miscompares           = 0;
    rst                     = 1'b1;
    u_if.upscale            = 1'b1;
    u_if.pix_valid          = 1'b0;
    u_if.pix_x              = 10'd0;
    u_if.pix_y              = 10'd0;
    u_if.pix_is_paddle      = 1'b0;
    u_if.frame_end          = 1'b0;
    u_if.ball_x             = 10'd600;
    u_if.ball_y             = 10'd0;
    u_if.is_ball_moving_left = 1'b0;
    repeat (3) tick();
    check_val("rst_found", u_if.paddle_found, 0);
    check_val("rst_cx", u_if.paddle_cx, 0);
    check_val("rst_cy", u_if.paddle_cy, 0);
    check_val("rst_speed", u_if.estimated_speed, 0);
    check_val("rst_coll", u_if.collision_detected, 0);
    rst = 1'b0;

    // 10x40 block at x=20..29, y=100..139
    feed_block(20, 29, 100, 139);
    check_val("s1_pre_commit_found", u_if.paddle_found, 0);
    end_frame();
    check_val("s1_found", u_if.paddle_found, 1);
    check_val("s1_cx", u_if.paddle_cx, 24);
    check_val("s1_cy", u_if.paddle_cy, 119);
    check_val("s1_speed", u_if.estimated_speed, 0);

    // Shifted +6,+3: speed 6+3
    feed_block(26, 35, 103, 142);
    end_frame();
    check_val("s2_found", u_if.paddle_found, 1);
    check_val("s2_cx", u_if.paddle_cx, 30);
    check_val("s2_cy", u_if.paddle_cy, 122);
    check_val("s2_speed", u_if.estimated_speed, 9);

    feed_block(0, 9, 5, 5);
    end_frame();
    check_val("s2_small_found", u_if.paddle_found, 0);
    check_val("s2_small_speed", u_if.estimated_speed, 0);

    // 31 pixels, 32nd arrives with frame_end and must count and widen the box
    feed_block(50, 80, 10, 10);
    u_if.pix_valid     = 1'b1;
    u_if.pix_is_paddle = 1'b1;
    u_if.pix_x         = 10'd100;
    u_if.pix_y         = 10'd20;
    u_if.frame_end     = 1'b1;
    tick();
    u_if.pix_valid     = 1'b0;
    u_if.pix_is_paddle = 1'b0;
    u_if.frame_end     = 1'b0;
    check_val("edge_found", u_if.paddle_found, 1);
    check_val("edge_cx", u_if.paddle_cx, 75);
    check_val("edge_cy", u_if.paddle_cy, 15);
    check_val("edge_speed_prev_invalid", u_if.estimated_speed, 0);

    // Back to scenario-1 box: |24-75| + |119-15| = 155
    feed_block(20, 29, 100, 139);
    end_frame();
    check_val("s3_box_cx", u_if.paddle_cx, 24);
    check_val("s3_box_speed", u_if.estimated_speed, 155);

    // Ball 40,220 upscaled -> 20,110 overlaps
    u_if.ball_x = 10'd40;
    u_if.ball_y = 10'd220;
    check_val("s3_same_cycle", u_if.collision_detected, 0);
    tick();
    check_val("s3_pulse", u_if.collision_detected, 1);
    check_val("s3_speed_in_pulse", u_if.estimated_speed, 155);
    count_pulses(500, pulses);
    check_val("s3_hold_no_repulse", pulses, 0);

    // Leaving without frame_end does not re-arm
    u_if.ball_x = 10'd200;
    count_pulses(3, pulses);
    u_if.ball_x = 10'd40;
    count_pulses(3, pulses);
    check_val("s4_no_rearm", pulses, 0);
    u_if.ball_x = 10'd200;
    feed_block(20, 29, 100, 139);
    end_frame();
    check_val("s4_found", u_if.paddle_found, 1);
    check_val("s4_speed", u_if.estimated_speed, 0);
    u_if.ball_x = 10'd40;
    tick();
    check_val("s4_pulse", u_if.collision_detected, 1);
    tick();
    check_val("s4_pulse_end", u_if.collision_detected, 0);

    // Direction toggle in COOLDOWN re-arms while overlap persists
    u_if.is_ball_moving_left = 1'b1;
    tick();
    check_val("s5_rearm_cycle", u_if.collision_detected, 0);
    tick();
    check_val("s5_pulse", u_if.collision_detected, 1);
    tick();
    check_val("s5_pulse_end", u_if.collision_detected, 0);

    // Reset mid-frame after 20 paddle pixels
    feed_block(20, 29, 100, 101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("s6_rst_found", u_if.paddle_found, 0);
    check_val("s6_rst_cx", u_if.paddle_cx, 0);
    check_val("s6_rst_coll", u_if.collision_detected, 0);
    end_frame();
    check_val("s6_found", u_if.paddle_found, 0);
    check_val("s6_speed", u_if.estimated_speed, 0);
    check_val("s6_cx_cleared", u_if.paddle_cx, 511);
    check_val("s6_cy_cleared", u_if.paddle_cy, 511);
    count_pulses(5, pulses);
    check_val("s6_no_hit_absent", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
